// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and baud defaults.
// The receiver is expected to import the same package.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Width of a counter that must hold the values 0..n-1, never narrower than one bit
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear restarts the bit period from zero.
module uart_tx_fifo_drain_baud
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_wrap
);

    localparam int W = cntWidth(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_wrap = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through TX FIFO onto the serial line.
// Frames are start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_ren,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic ODD_BIT   = (PARITY_ODD != 0);
    localparam bit   HAS_PAR   = (PARITY_EN != 0);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [BW-1:0]         r_bitCnt;
    logic                  r_stopCnt;
    logic                  r_tx;
    logic                  r_txDone;

    logic                  w_wrap;
    logic                  w_lastStop;
    logic                  w_ren;
    logic                  w_baudClear;
    logic [DATA_WIDTH-1:0] w_shiftNext;

    // A pop can happen from IDLE or on the final stop cycle, which chains frames with no gap
    assign w_lastStop  = (r_state == STOP) && w_wrap && (r_stopCnt == STOP_LAST);
    assign w_ren       = ~fifo_empty & ((r_state == IDLE) | w_lastStop);
    assign w_baudClear = (r_state == IDLE) | w_ren;
    assign w_shiftNext = r_shift >> 1;

    uart_tx_fifo_drain_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_baudClear),
        .o_wrap (w_wrap)
    );

    // Frame sequencer; tx only moves on a bit boundary or when a new word is popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_tx      <= 1'b1;
            r_txDone  <= 1'b0;
        end else begin
            r_txDone <= w_lastStop;
            if (w_ren) begin
                r_shift  <= fifo_data;
                r_parity <= ^fifo_data;
                r_state  <= START;
                r_tx     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tx <= 1'b1;
                    end
                    START: begin
                        if (w_wrap) begin
                            r_state  <= DATA;
                            r_tx     <= r_shift[0];
                            r_bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        if (w_wrap) begin
                            if (r_bitCnt == LAST_BIT) begin
                                r_stopCnt <= 1'b0;
                                if (HAS_PAR) begin
                                    r_state <= PARITY;
                                    r_tx    <= r_parity ^ ODD_BIT;
                                end else begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_shift  <= w_shiftNext;
                                r_tx     <= w_shiftNext[0];
                                r_bitCnt <= r_bitCnt + BW'(1);
                            end
                        end
                    end
                    PARITY: begin
                        if (w_wrap) begin
                            r_state   <= STOP;
                            r_tx      <= 1'b1;
                            r_stopCnt <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (w_wrap) begin
                            if (r_stopCnt == STOP_LAST) begin
                                r_state <= IDLE;
                            end else begin
                                r_stopCnt <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign fifo_ren = w_ren;
    assign tx       = r_tx;
    assign busy     = (r_state != IDLE);
    assign tx_done  = r_txDone;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances with different framing options, one active at a time,
// checked cycle by cycle against a bit-list frame model fed from a FIFO queue.
module tb_uart_tx_fifo_drain;

    localparam int NI = 4;
    localparam int CPB = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NI-1:0]  emptyV;
    logic [7:0]     dataV [NI];
    wire  [NI-1:0]  renV;
    wire  [NI-1:0]  txV;
    wire  [NI-1:0]  busyV;
    wire  [NI-1:0]  doneV;

    int parEnA  [NI] = '{0, 1, 1, 0};
    int parOddA [NI] = '{0, 0, 1, 0};
    int stopA   [NI] = '{1, 1, 1, 2};

    logic [7:0] fifoQ[$];
    logic       expQ[$];
    logic       txTrace[$];
    int         popCycles[$];
    int         doneCycles[$];
    bit         donePending;
    int         busyCount;
    int         active;
    int         checks;
    int         errors;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(emptyV[0]), .fifo_data(dataV[0]),
        .fifo_ren(renV[0]), .tx(txV[0]), .busy(busyV[0]), .tx_done(doneV[0]));
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(emptyV[1]), .fifo_data(dataV[1]),
        .fifo_ren(renV[1]), .tx(txV[1]), .busy(busyV[1]), .tx_done(doneV[1]));
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .fifo_empty(emptyV[2]), .fifo_data(dataV[2]),
        .fifo_ren(renV[2]), .tx(txV[2]), .busy(busyV[2]), .tx_done(doneV[2]));
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .fifo_empty(emptyV[3]), .fifo_data(dataV[3]),
        .fifo_ren(renV[3]), .tx(txV[3]), .busy(busyV[3]), .tx_done(doneV[3]));

    // Only the active instance sees a non-empty FIFO; idle heads carry junk to prove data is ignored
    task automatic driveFifo();
        for (int k = 0; k < NI; k++) begin
            if (k == active && fifoQ.size() > 0) begin
                emptyV[k] = 1'b0;
                dataV[k]  = fifoQ[0];
            end else begin
                emptyV[k] = 1'b1;
                dataV[k]  = 8'($urandom);
            end
        end
    endtask

    task automatic pushFrame(input int k, input logic [7:0] w);
        logic bits[$];
        logic p;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(w[b]);
        if (parEnA[k] != 0) begin
            p = ^w;
            if (parOddA[k] != 0) p = ~p;
            bits.push_back(p);
        end
        for (int s = 0; s < stopA[k]; s++) bits.push_back(1'b1);
        foreach (bits[i]) repeat (CPB) expQ.push_back(bits[i]);
    endtask

    // One clock of the reference: compare outputs at the falling edge, pop the FIFO after the rising edge
    task automatic step(input int k);
        logic expTx, expBusy, expDone, expRen;
        int   idx;
        bit   doPop;
        @(negedge clk);
        idx     = txTrace.size();
        expDone = donePending;
        if (expQ.size() > 0) begin
            expTx       = expQ.pop_front();
            expBusy     = 1'b1;
            donePending = (expQ.size() == 0);
        end else begin
            expTx       = 1'b1;
            expBusy     = 1'b0;
            donePending = 1'b0;
        end
        expRen = (fifoQ.size() > 0) && (expQ.size() == 0);
        checks += 4;
        if (txV[k] !== expTx) begin
            errors++;
            $display("[TB] FAIL tx inst%0d cycle %0d: got %b expected %b", k, idx, txV[k], expTx);
        end
        if (busyV[k] !== expBusy) begin
            errors++;
            $display("[TB] FAIL busy inst%0d cycle %0d: got %b expected %b", k, idx, busyV[k], expBusy);
        end
        if (doneV[k] !== expDone) begin
            errors++;
            $display("[TB] FAIL tx_done inst%0d cycle %0d: got %b expected %b", k, idx, doneV[k], expDone);
        end
        if (renV[k] !== expRen) begin
            errors++;
            $display("[TB] FAIL fifo_ren inst%0d cycle %0d: got %b expected %b", k, idx, renV[k], expRen);
        end
        txTrace.push_back(txV[k]);
        if (busyV[k] === 1'b1) busyCount++;
        if (doneV[k] === 1'b1) doneCycles.push_back(idx);
        if (renV[k] === 1'b1) popCycles.push_back(idx);
        if (expRen) pushFrame(k, fifoQ[0]);
        doPop = (renV[k] === 1'b1) && (fifoQ.size() > 0);
        @(posedge clk);
        #1;
        if (doPop) void'(fifoQ.pop_front());
        driveFifo();
    endtask

    task automatic runUntilIdle(input int k, input int budget);
        int n = 0;
        do begin
            step(k);
            n++;
        end while ((expQ.size() > 0 || fifoQ.size() > 0 || donePending) && n < budget);
        checks++;
        if (expQ.size() > 0 || fifoQ.size() > 0 || donePending) begin
            errors++;
            $display("[TB] FAIL timeout inst%0d: got %0d cycles without draining, required under %0d", k, n, budget);
        end
    endtask

    task automatic clearStats(input int k);
        active = k;
        popCycles.delete();
        doneCycles.delete();
        busyCount = 0;
        driveFifo();
    endtask

    // Word recovered from the trace by sampling the middle of each data bit of the frame popped at p
    function automatic logic [7:0] decodeAt(input int p);
        logic [7:0] w;
        for (int b = 0; b < 8; b++) w[b] = txTrace[p + 1 + CPB * (b + 1) + 2];
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        active = 0;
        driveFifo();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks += 4;
            if (txV[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_tx inst%0d: got %b expected 1", k, txV[k]);
            end
            if (busyV[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy inst%0d: got %b expected 0", k, busyV[k]);
            end
            if (doneV[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_done inst%0d: got %b expected 0", k, doneV[k]);
            end
            if (renV[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ren inst%0d: got %b expected 0", k, renV[k]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int lows;
        int start;
        clearStats(0);
        start = txTrace.size();
        repeat (1000) step(0);
        lows = 0;
        for (int i = start; i < txTrace.size(); i++) if (txTrace[i] !== 1'b1) lows++;
        checks += 3;
        if (lows != 0) begin
            errors++;
            $display("[TB] FAIL idle_tx_low: got %0d low cycles expected 0", lows);
        end
        if (busyCount != 0) begin
            errors++;
            $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busyCount);
        end
        if (popCycles.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_pops: got %0d expected 0", popCycles.size());
        end
    endtask

    task automatic test_single();
        logic expPat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   p;
        int   bad;
        clearStats(0);
        fifoQ.push_back(8'h55);
        driveFifo();
        runUntilIdle(0, 200);
        checks += 4;
        if (popCycles.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_pops: got %0d expected 1", popCycles.size());
        end
        if (doneCycles.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_dones: got %0d expected 1", doneCycles.size());
        end
        if (doneCycles[0] - popCycles[0] != 41) begin
            errors++;
            $display("[TB] FAIL single_done_latency: got %0d expected 41", doneCycles[0] - popCycles[0]);
        end
        if (busyCount != 40) begin
            errors++;
            $display("[TB] FAIL single_busy_len: got %0d expected 40", busyCount);
        end
        p = popCycles[0];
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int j = 1; j <= CPB; j++) if (txTrace[p + CPB * b + j] !== expPat[b]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL single_bit%0d: got %0d wrong samples expected level %b", b, bad, expPat[b]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clearStats(0);
        fifoQ.push_back(8'hA5);
        fifoQ.push_back(8'h3C);
        driveFifo();
        runUntilIdle(0, 300);
        checks += 5;
        if (popCycles.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_pops: got %0d expected 2", popCycles.size());
        end
        if (popCycles[1] - popCycles[0] != 40) begin
            errors++;
            $display("[TB] FAIL b2b_pop_gap: got %0d expected 40", popCycles[1] - popCycles[0]);
        end
        if (doneCycles.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_dones: got %0d expected 2", doneCycles.size());
        end
        if (busyCount != 80) begin
            errors++;
            $display("[TB] FAIL b2b_busy_len: got %0d expected 80", busyCount);
        end
        if (txTrace[popCycles[0] + 41] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_start: got %b expected 0", txTrace[popCycles[0] + 41]);
        end
    endtask

    task automatic test_parity();
        logic expPar;
        int   p;
        for (int k = 1; k <= 2; k++) begin
            clearStats(k);
            expPar = (k == 1) ? 1'b1 : 1'b0;
            fifoQ.push_back(8'h07);
            driveFifo();
            runUntilIdle(k, 200);
            p = popCycles[0];
            checks += 3;
            if (txTrace[p + 1 + CPB * 9 + 1] !== expPar) begin
                errors++;
                $display("[TB] FAIL parity_bit inst%0d: got %b expected %b", k, txTrace[p + 1 + CPB * 9 + 1], expPar);
            end
            if (busyCount != 44) begin
                errors++;
                $display("[TB] FAIL parity_frame_len inst%0d: got %0d expected 44", k, busyCount);
            end
            if (doneCycles[0] - p != 45) begin
                errors++;
                $display("[TB] FAIL parity_done_latency inst%0d: got %0d expected 45", k, doneCycles[0] - p);
            end
        end
    endtask

    task automatic test_reset_mid();
        clearStats(0);
        fifoQ.push_back(8'hF0);
        driveFifo();
        repeat (19) step(0);
        checks++;
        if (txV[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset_bit3: got %b expected 0", txV[0]);
        end
        reset = 1'b1;
        #1;
        checks += 2;
        if (txV[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_tx: got %b expected 1", txV[0]);
        end
        if (busyV[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_busy: got %b expected 0", busyV[0]);
        end
        expQ.delete();
        donePending = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clearStats(0);
        fifoQ.push_back(8'h81);
        driveFifo();
        runUntilIdle(0, 200);
        checks += 3;
        if (popCycles.size() != 1) begin
            errors++;
            $display("[TB] FAIL postreset_pops: got %0d expected 1", popCycles.size());
        end
        if (decodeAt(popCycles[0]) !== 8'h81) begin
            errors++;
            $display("[TB] FAIL postreset_word: got %h expected 81", decodeAt(popCycles[0]));
        end
        if (doneCycles.size() != 1) begin
            errors++;
            $display("[TB] FAIL postreset_dones: got %0d expected 1", doneCycles.size());
        end
    endtask

    task automatic test_stop2();
        int p;
        int highs;
        clearStats(3);
        for (int i = 0; i < 16; i++) fifoQ.push_back(8'(i));
        driveFifo();
        runUntilIdle(3, 2000);
        checks++;
        if (popCycles.size() != 16) begin
            errors++;
            $display("[TB] FAIL stop2_pops: got %0d expected 16", popCycles.size());
        end
        for (int i = 0; i < popCycles.size(); i++) begin
            checks++;
            if (decodeAt(popCycles[i]) !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL stop2_word%0d: got %h expected %h", i, decodeAt(popCycles[i]), 8'(i));
            end
        end
        p = popCycles[0];
        highs = 0;
        for (int c = p + 37; c <= p + 44; c++) if (txTrace[c] === 1'b1) highs++;
        checks += 2;
        if (highs != 8) begin
            errors++;
            $display("[TB] FAIL stop2_high_time: got %0d expected 8", highs);
        end
        if (txTrace[p + 45] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop2_next_start: got %b expected 0", txTrace[p + 45]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin
            clearStats(k);
            for (int n = 0; n < 10; n++) begin
                fifoQ.push_back(8'($urandom));
                driveFifo();
                repeat ($urandom_range(0, 60)) step(k);
            end
            runUntilIdle(k, 1000);
            checks += 2;
            if (popCycles.size() != 10) begin
                errors++;
                $display("[TB] FAIL random_pops inst%0d: got %0d expected 10", k, popCycles.size());
            end
            if (doneCycles.size() != 10) begin
                errors++;
                $display("[TB] FAIL random_dones inst%0d: got %0d expected 10", k, doneCycles.size());
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        busyCount   = 0;
        donePending = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_stop2();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name:
uart_tx_fifo_drain

Overview:
- UART transmitter that drains the single-clock TX FIFO through its read side.
- FIFO side is first-word-fall-through: data is valid while empty=0, and one ren cycle pops it.
- Serialises each popped word as start bit, DATA_WIDTH data bits (LSB first), optional parity, then STOP_BITS stop bits on line tx.
- Sits between the TX FIFO and the board UART TX pin on Nexys4DDR.

Parameters:
- DATA_WIDTH, 8: word width popped from the FIFO and sent per frame.
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200). Must be >= 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO head word, valid while fifo_empty=0.
- fifo_ren  out  1  FIFO read request; one cycle pops one word.
- tx  out  1  serial line, idles high.
- busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: tx=1, busy=0, tx_done=0, fifo_ren=0, state=IDLE, all counters 0. Shift register contents are don't-care.
- States: IDLE, START, DATA, PARITY, STOP.
- fifo_ren is combinational: (state==IDLE & ~fifo_empty) | (last STOP cycle & ~fifo_empty). It is never high while fifo_empty=1.
- On any cycle with fifo_ren=1, the following are all loaded at that clock edge:
  - shift_reg <= fifo_data
  - parity accumulator <= XOR of fifo_data
  - state <= START, tx <= 0, baud_cnt <= 0
- Bit timing:
  - baud_cnt counts 0..CLKS_PER_BIT-1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx is registered and changes only when baud_cnt wraps.
- START to DATA: tx <= shift_reg[0], bit_cnt <= 0.
- DATA:
  - Each wrap shifts right and increments bit_cnt.
  - After bit DATA_WIDTH-1: go to PARITY if PARITY_EN=1, otherwise to STOP with tx <= 1.
- PARITY: tx = even parity of the data, inverted when PARITY_ODD=1. Lasts one bit time, then STOP with tx=1.
- STOP: lasts STOP_BITS*CLKS_PER_BIT cycles. On its last cycle:
  - If ~fifo_empty: pop and go directly to START, so back-to-back frames have zero idle cycles.
  - Otherwise: go to IDLE.
- tx_done: registered, high for the one cycle after the last STOP cycle, whether or not a new frame follows.
- busy = (state != IDLE).
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- First-bit latency: tx falls 1 cycle after the first IDLE cycle that sees fifo_empty=0.
- fifo_empty or fifo_data changing mid-frame has no effect; the word is captured at pop.
- Reset mid-frame: tx returns to 1 asynchronously and the word is discarded, with no re-read.
- Width rules:
  - baud_cnt width: $clog2(CLKS_PER_BIT).
  - bit_cnt width: $clog2(DATA_WIDTH)+1.
  - stop_cnt: 1 bit.
  - All counter compares are against parameter-derived constants, with no overflow.

Decomposition:
- Shared include uart_defs.vh: state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit) and the default CLKS_PER_BIT for 100 MHz / 115200. Also used by the future receiver.
- Optional sub-module uart_baud_counter: CLKS_PER_BIT counter with synchronous clear and wrap output. Everything else is inline.

Test Plan:
- CLKS_PER_BIT=4, push 0x55 into an empty FIFO -> fifo_ren high for 1 cycle; tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done pulses once at cycle 41 after the pop; busy high for 40 cycles.
- Preload 0xA5 and 0x3C -> exactly 2 fifo_ren pulses 40 cycles apart; no idle-high gap between the first stop bit and the second start bit; 2 tx_done pulses.
- FIFO held empty for 1000 cycles -> tx=1, fifo_ren=0, busy=0 throughout.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame length 44 cycles.
- Assert reset during data bit 3 of 0xF0 -> tx=1 and busy=0 the same cycle; after release, the next word 0x81 is sent correctly and 0xF0 is not resent.
- Fill the FIFO with 16 words 0x00..0x0F, STOP_BITS=2 -> 16 pops; the scoreboard decodes all 16 in order; stop-bit high time is 8 cycles.
